snd_cmd_tx: RTL and testbench

SND_CMD_TX -- requirements
Module: snd_cmd_tx

---
 rtl/snd_cmd_tx.sv | 162 ++++++++++++++++
 tb/tb_snd_cmd_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_cmd_tx.sv
// -----------------------------------------------------------------------------
// snd_cmd_tx -- main-CPU to audio-CPU sound command transmitter.
//
// Bytes written by the main CPU are queued. Each one is handed to the audio
// side as a one-cycle latch-load pulse, and an NMI is then held until the
// audio CPU acknowledges the read. If no ack arrives within TIMEOUT cpu_cen
// ticks, the command is abandoned and the next one is sent.
//
// Optional feature macro: SND_CMD_FIFO_EN
//   defined   : 2^DEPTH_LOG2-entry command FIFO; overflow drops the new byte.
//   undefined : single holding register; overflow overwrites (newest wins).
//
// Ports:
//   clk_sys    in   system clock (only clock)
//   reset      in   synchronous active-high reset
//   cpu_cen    in   audio CPU clock enable, times the ack timeout
//   wr_stb     in   main CPU write strobe (one cycle)
//   wr_data    in   command byte
//   ack        in   audio CPU read-of-latch strobe (one cycle)
//   snd_write  out  latch-load pulse
//   snd_dout   out  command byte presented with snd_write
//   snd_nmi    out  interrupt request, high while awaiting ack
//   busy       out  state not IDLE or commands queued
//   level      out  number of queued commands
//   ovf        out  sticky: a command was lost
// -----------------------------------------------------------------------------
module snd_cmd_tx #(
   parameter int TIMEOUT    = 4095,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  cpu_cen,
   input  logic                  wr_stb,
   input  logic [7:0]            wr_data,
   input  logic                  ack,
   output logic                  snd_write,
   output logic [7:0]            snd_dout,
   output logic                  snd_nmi,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ovf
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   timer;
   logic [7:0]      head;
   logic            pop;
   logic            tmo_hit;

   // A command leaves the queue only when the transmitter is free.
   assign pop     = (state == S_IDLE) && (level != '0);
   // The tick that brings the timer up to TIMEOUT ends the wait.
   assign tmo_hit = cpu_cen && (timer == TW'(TIMEOUT - 1));

   // ---------------- state register ----------------
   always_ff @(posedge clk_sys) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (level != '0) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_WAIT;
         S_WAIT: begin
            // ack wins over a coincident timeout; both just return to IDLE.
            if (ack)          state_nxt = S_IDLE;
            else if (tmo_hit) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      snd_write = (state == S_LOAD);
      snd_nmi   = (state == S_WAIT);
      busy      = (state != S_IDLE) || (level != '0);
   end

   // ---------------- ack timer ----------------
   always_ff @(posedge clk_sys) begin
      if (reset)                             timer <= '0;
      else if (state == S_LOAD)              timer <= '0;
      else if (state == S_WAIT && cpu_cen && !ack) timer <= timer + 1'b1;
   end

   // ---------------- output data register ----------------
   // Only loaded on a pop, so later writes cannot disturb an in-flight byte.
   always_ff @(posedge clk_sys) begin
      if (reset)    snd_dout <= 8'h00;
      else if (pop) snd_dout <= head;
   end

`ifdef SND_CMD_FIFO_EN
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  full;
   logic                  push;

   assign full = (level == (DEPTH_LOG2 + 1)'(DEPTH));
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push = wr_stb && (!full || pop);
   assign head = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (wr_stb && full && !pop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
`else
   logic [7:0] hold;
   logic       occ;

   assign head  = hold;
   assign level = {{DEPTH_LOG2{1'b0}}, occ};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         occ <= 1'b0;
         ovf <= 1'b0;
      end else begin
         if (wr_stb)   occ <= 1'b1;
         else if (pop) occ <= 1'b0;
         // Overwriting an unsent byte loses it; a same-cycle pop does not.
         if (wr_stb && occ && !pop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_stb) hold <= wr_data;
   end
`endif

endmodule

// File: tb/tb_snd_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_snd_cmd_tx -- self-checking bench for snd_cmd_tx.
// Expected command bytes are queued by the stimulus; a forked monitor pops
// and compares on every snd_write pulse. Status outputs are checked directly.
// Build-dependent expectations follow SND_CMD_FIFO_EN.
// -----------------------------------------------------------------------------
module tb_snd_cmd_tx;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       cpu_cen;
   logic       wr_stb;
   logic [7:0] wr_data;
   logic       ack;
   logic       snd_write;
   logic [7:0] snd_dout;
   logic       snd_nmi;
   logic       busy;
   logic [2:0] level;
   logic       ovf;

   int         checks = 0;
   int         errors = 0;
   int         wr_pulses = 0;
   logic [7:0] exp_q [$];

   snd_cmd_tx #(.TIMEOUT(4095), .DEPTH_LOG2(2)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .cpu_cen   (cpu_cen),
      .wr_stb    (wr_stb),
      .wr_data   (wr_data),
      .ack       (ack),
      .snd_write (snd_write),
      .snd_dout  (snd_dout),
      .snd_nmi   (snd_nmi),
      .busy      (busy),
      .level     (level),
      .ovf       (ovf)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit expect_out);
      wr_stb  = 1'b1;
      wr_data = d;
      if (expect_out) exp_q.push_back(d);
      tick();
      wr_stb = 1'b0;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      wr_stb = 1'b0;
      ack    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_nmi(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (snd_nmi) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_nmi actual=timeout required=snd_nmi_high");
      end
   endtask

   task automatic ack_one();
      bit ok;
      wait_nmi(ok);
      if (ok) begin
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
   endtask

   initial begin
      bit ok;
      int hi;
      int p0;

      reset   = 1'b1;
      cpu_cen = 1'b0;
      wr_stb  = 1'b0;
      wr_data = 8'h00;
      ack     = 1'b0;

      fork
         forever begin
            @(negedge clk_sys);
            if (snd_write === 1'b1) begin
               wr_pulses++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write actual=%02h required=none", snd_dout);
               end else begin
                  chk("snd_dout", {24'h0, snd_dout}, {24'h0, exp_q.pop_front()});
               end
            end
         end
      join_none

      // reset; strobes during reset are ignored
      tick();
      tick();
      wr_stb  = 1'b1;
      wr_data = 8'h77;
      tick();
      wr_stb = 1'b0;
      ack    = 1'b1;
      tick();
      ack   = 1'b0;
      reset = 1'b0;
      chk("rst_snd_write", 32'(snd_write), 0);
      chk("rst_snd_nmi",   32'(snd_nmi),   0);
      chk("rst_snd_dout",  32'(snd_dout),  0);
      chk("rst_level",     32'(level),     0);
      chk("rst_ovf",       32'(ovf),       0);
      chk("rst_busy",      32'(busy),      0);
      tick();
      tick();
      chk("rst_wr_ignored", 32'(level), 0);

      // basic latency: strobe in N, snd_write in N+2, nmi until ack
      wr(8'h5A, 1'b1);
      chk("lat_n1_write", 32'(snd_write), 0);
      chk("lat_n1_busy",  32'(busy),      1);
      tick();
      chk("lat_n2_write", 32'(snd_write), 1);
      chk("lat_n2_dout",  32'(snd_dout),  32'h5A);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("nmi_wait", 32'(snd_nmi), 1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("nmi_after_ack",  32'(snd_nmi), 0);
      chk("busy_after_ack", 32'(busy),    0);

      // ack in IDLE and LOAD is ignored
      wr(8'hE1, 1'b1);
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      chk("ack_ignored_load", 32'(snd_nmi), 1);
      ack_one();

      // queue build: the first byte drains into LOAD at once, so six writes
      // are needed to overflow a 4-entry FIFO
      do_reset();
      for (int i = 1; i <= 6; i++) begin
`ifdef SND_CMD_FIFO_EN
         wr(8'(i), i <= 5);
`else
         wr(8'(i), (i == 1) || (i == 6));
`endif
      end
`ifdef SND_CMD_FIFO_EN
      chk("fifo_level", 32'(level), 4);
`else
      chk("fifo_level", 32'(level), 1);
`endif
      chk("fifo_ovf", 32'(ovf), 1);
      chk("fifo_nmi", 32'(snd_nmi), 1);
`ifdef SND_CMD_FIFO_EN
      for (int i = 0; i < 5; i++) ack_one();
`else
      for (int i = 0; i < 2; i++) ack_one();
`endif
      tick();
      tick();
      tick();
      chk("fifo_drained", 32'(level), 0);
      chk("fifo_sb_empty", 32'(exp_q.size()), 0);

      // timeout with cpu_cen held high
      do_reset();
      cpu_cen = 1'b1;
      wr(8'hA1, 1'b1);
      wr(8'hA2, 1'b1);
      wait_nmi(ok);
      hi = 1;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (!snd_nmi) break;
         hi++;
      end
      chk("timeout_ticks", 32'(hi), 4095);
      chk("timeout_no_ovf", 32'(ovf), 0);
      ack_one();

      // ack and timeout in the same cycle
      wr(8'hC1, 1'b1);
      wr(8'hC2, 1'b1);
      wait_nmi(ok);
      hi = 1;
      while (hi < 4095) begin
         tick();
         hi++;
      end
      chk("nmi_before_tie", 32'(snd_nmi), 1);
      p0  = wr_pulses;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("tie_idle_nmi",   32'(snd_nmi),   0);
      chk("tie_idle_write", 32'(snd_write), 0);
      tick();
      chk("tie_reload", 32'(snd_write), 1);
      tick();
      chk("tie_wait", 32'(snd_nmi), 1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      tick();
      chk("tie_single_load", 32'(wr_pulses - p0), 1);
      chk("tie_sb_empty", 32'(exp_q.size()), 0);
      cpu_cen = 1'b0;

      // reset in WAIT with commands queued
      do_reset();
      wr(8'h31, 1'b1);
      wr(8'h32, 1'b0);
      wr(8'h33, 1'b0);
      wait_nmi(ok);
`ifdef SND_CMD_FIFO_EN
      chk("midrst_level_pre", 32'(level), 2);
`else
      chk("midrst_level_pre", 32'(level), 1);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_ovf",  32'(ovf),      0);
      chk("midrst_dout", 32'(snd_dout), 0);
      for (int i = 0; i < 10; i++) begin
         chk("midrst_nmi",   32'(snd_nmi),   0);
         chk("midrst_level", 32'(level),     0);
         chk("midrst_write", 32'(snd_write), 0);
         tick();
      end

      // two writes while a command is in WAIT
      do_reset();
      wr(8'h90, 1'b1);
      wait_nmi(ok);
`ifdef SND_CMD_FIFO_EN
      wr(8'hAA, 1'b1);
`else
      wr(8'hAA, 1'b0);
`endif
      wr(8'hBB, 1'b1);
`ifdef SND_CMD_FIFO_EN
      chk("hold_ovf",   32'(ovf),   0);
      chk("hold_level", 32'(level), 2);
`else
      chk("hold_ovf",   32'(ovf),   1);
      chk("hold_level", 32'(level), 1);
`endif
      ack_one();
      wait_nmi(ok);
`ifdef SND_CMD_FIFO_EN
      chk("hold_dout_1", 32'(snd_dout), 32'hAA);
      ack_one();
      wait_nmi(ok);
`endif
      chk("hold_dout_last", 32'(snd_dout), 32'hBB);
      ack_one();
      tick();
      tick();
      chk("final_sb_empty", 32'(exp_q.size()), 0);
      chk("final_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
